led_pattern_gen: RTL

LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

---
 rtl/led_pattern_pkg.sv | 22 ++
 rtl/led_tick_gen.sv | 39 +++
 rtl/led_pattern_gen.sv | 109 ++++++++++
 3 files changed

// File: rtl/led_pattern_pkg.sv
// Shared encodings for the LED pattern generator: pattern modes, ping-pong
// direction and fill/drain phase.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_ROL  = 2'b00,
    MODE_ROR  = 2'b01,
    MODE_PING = 2'b10,
    MODE_FILL = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_e;

  typedef enum logic {
    PHASE_FILL  = 1'b0,
    PHASE_DRAIN = 1'b1
  } phase_e;

endpackage

// File: rtl/led_tick_gen.sv
// Step-period prescaler: counts enabled cycles and flags a tick once the count
// reaches the programmed period, then restarts from zero.
module led_tick_gen #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic             clr,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // A >= compare makes a period lowered below the running count fire at once.
  assign tick = en && (cnt_q >= period);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: rotate-left, rotate-right, ping-pong and fill/drain
// patterns advanced by a programmable prescaler tick.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int unsigned LED_W = 8,
  parameter int unsigned CNT_W = 24
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] period,
  output logic [LED_W-1:0] led_out,
  output logic             step
);

  mode_e            mode_in;
  mode_e            mode_q,  mode_d;
  dir_e             dir_q,   dir_d;
  phase_e           phase_q, phase_d;
  logic [LED_W-1:0] led_q,   led_d;
  logic             step_q,  step_d;
  logic             mode_chg_c;
  logic             tick_c;

  assign mode_in    = mode_e'(mode);
  assign mode_chg_c = (mode_in != mode_q);

  led_tick_gen #(
    .CNT_W (CNT_W)
  ) u_tick_gen (
    .clk    (sys_clk),
    .rst    (sys_rst),
    .en     (en),
    .period (period),
    .clr    (mode_chg_c),
    .tick   (tick_c)
  );

  // Mode change reseeds the pattern and swallows any coincident tick.
  always_comb begin
    mode_d  = mode_q;
    dir_d   = dir_q;
    phase_d = phase_q;
    led_d   = led_q;
    step_d  = 1'b0;
    if (mode_chg_c) begin
      mode_d  = mode_in;
      dir_d   = DIR_LEFT;
      phase_d = PHASE_FILL;
      led_d   = (mode_in == MODE_FILL) ? '0 : LED_W'(1);
    end else if (tick_c) begin
      step_d = 1'b1;
      case (mode_q)
        MODE_ROL: led_d = {led_q[LED_W-2:0], led_q[LED_W-1]};
        MODE_ROR: led_d = {led_q[0], led_q[LED_W-1:1]};
        MODE_PING: begin
          // Bounce at either end without repeating the end position.
          if (dir_q == DIR_LEFT) begin
            if (led_q[LED_W-1]) begin
              dir_d = DIR_RIGHT;
              led_d = {1'b0, led_q[LED_W-1:1]};
            end else begin
              led_d = {led_q[LED_W-2:0], 1'b0};
            end
          end else begin
            if (led_q[0]) begin
              dir_d = DIR_LEFT;
              led_d = {led_q[LED_W-2:0], 1'b0};
            end else begin
              led_d = {1'b0, led_q[LED_W-1:1]};
            end
          end
        end
        MODE_FILL: begin
          if (phase_q == PHASE_FILL) begin
            led_d = {led_q[LED_W-2:0], 1'b1};
            if (&led_d) phase_d = PHASE_DRAIN;
          end else begin
            led_d = {led_q[LED_W-2:0], 1'b0};
            if (led_d == '0) phase_d = PHASE_FILL;
          end
        end
        default: led_d = led_q;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mode_q  <= MODE_ROL;
      dir_q   <= DIR_LEFT;
      phase_q <= PHASE_FILL;
      led_q   <= LED_W'(1);
      step_q  <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      phase_q <= phase_d;
      led_q   <= led_d;
      step_q  <= step_d;
    end
  end

  assign led_out = led_q;
  assign step    = step_q;

endmodule
